wallace_dot_accumulator: RTL

- Downstream consumer of the 5x5 Wallace multiplier (top_level_reduction), which produces a 10-bit product P from 5-bit operands A and B.
- Accumulates a stream of products into a dot-product sum.
- Closes a group on an explicit last flag, or when the term count reaches MAX_TERMS.
- Presents each group's result on a valid/ready output held stable until accepted, so vector dot products can be built on the multiplier without extra glue.

---
 rtl/wallace_pkg.sv | 12 +
 rtl/wallace_dot_accumulator_if.sv | 29 ++
 rtl/wallace_dot_accumulator.sv | 98 +++++++++
 3 files changed

// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared widths and accumulator state encoding for the Wallace multiplier datapath
package wallace_pkg;

  localparam int PROD_W    = 10;
  localparam int OPERAND_W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/wallace_dot_accumulator_if.sv
// rtl/wallace_dot_accumulator_if.sv - product stream in, group result out
interface wallace_dot_accumulator_if #(
  parameter int PROD_W    = wallace_pkg::PROD_W,
  parameter int MAX_TERMS = 64
);

  localparam int ACC_W = PROD_W + $clog2(MAX_TERMS);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/wallace_dot_accumulator.sv
// rtl/wallace_dot_accumulator.sv - sums multiplier products into per-group dot-product results
module wallace_dot_accumulator
  import wallace_pkg::*;
#(
  parameter int PROD_W    = wallace_pkg::PROD_W,
  parameter int MAX_TERMS = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  wallace_dot_accumulator_if.slave bus
);

  localparam int ACC_W = PROD_W + $clog2(MAX_TERMS);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

  acc_state_t       state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_en;
  logic             in_ready;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // in_ready stays low until the first edge after reset release
  assign in_ready = ready_en && (state == ACCUM);
  assign acc_next = acc + {{(ACC_W-PROD_W){1'b0}}, bus.in_prod};
  assign cnt_next = cnt + CNT_W'(1);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    sum_d   = sum_q;
    count_d = count_q;
    if (clr) begin
      // abort wins over any handshake; held result registers keep stale values
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid && in_ready) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            if (bus.in_last || (cnt == LAST_IDX)) begin
              sum_d   = acc_next;
              count_d = cnt_next;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      ready_en <= 1'b0;
    end else begin
      acc      <= acc_d;
      cnt      <= cnt_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      ready_en <= 1'b1;
    end
  end

endmodule
